// File: rtl/video_burst_fetcher.sv
// Video SDRAM client: fetches one frame in fixed bursts into a pixel FIFO
// and presents the pixels with first-word-fall-through timing.
module video_burst_fetcher #(
  parameter int BURST_LEN   = 8,
  parameter int FIFO_DEPTH  = 32,
  parameter int FRAME_WORDS = 76800
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [23:0] fb_base_i,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic [15:0] pix_data_o,
  output logic        underflow_o,
  output logic        busy_o,
  output logic        video_sdram_cmd_valid,
  input  logic        video_sdram_cmd_ready,
  output logic [23:0] video_sdram_addr_x16,
  input  logic        video_sdram_rdy,
  output logic        video_sdram_ack,
  input  logic        video_sdram_resp_valid,
  input  logic        video_sdram_resp_last,
  input  logic [15:0] video_sdram_rdata
);

  localparam int RW = $clog2(FRAME_WORDS + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [RW-1:0] FRAME_R = RW'(FRAME_WORDS);
  localparam logic [RW-1:0] BURST_R = RW'(BURST_LEN);
  localparam logic [CW-1:0] ROOM    = CW'(FIFO_DEPTH - BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, DATA, ACK} state_t;

  state_t        state_q, state_d;
  logic [23:0]   addr_q, addr_d;
  logic [23:0]   base_q, base_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          pend_q, pend_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          unf_q, unf_d;
  logic [15:0]   mem_q [FIFO_DEPTH];

  logic pix_valid;
  logic flush;
  logic push;
  logic pop;
  logic rlast;

  assign pix_valid = (cnt_q != '0);
  assign rlast     = video_sdram_resp_valid & video_sdram_resp_last;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    rem_d   = rem_q;
    pend_d  = pend_q;
    last_d  = last_q;
    busy_d  = busy_q;
    flush   = 1'b0;
    push    = 1'b0;
    unf_d   = unf_q | (busy_q & pix_ready_i & ~pix_valid &
                       ((rem_q != '0) | (state_q != IDLE)));
    if (start_i) begin
      unf_d  = 1'b0;
      base_d = fb_base_i;
      busy_d = 1'b1;
      flush  = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d = fb_base_i;
          rem_d  = FRAME_R;
        end else if (rem_q == '0) begin
          busy_d = 1'b0;
        end else if (cnt_q <= ROOM) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (start_i) pend_d = 1'b1;
        if (video_sdram_cmd_ready) begin
          state_d = DATA;
          last_d  = 1'b0;
        end
      end
      DATA: begin
        // A restart drops the rest of the burst but lets the SDRAM finish
        if (start_i) pend_d = 1'b1;
        push = video_sdram_resp_valid & ~pend_q & ~start_i;
        if (rlast) last_d = 1'b1;
        if ((last_q | rlast) & video_sdram_rdy) state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
        pend_d  = 1'b0;
        if (start_i | pend_q) begin
          addr_d = start_i ? fb_base_i : base_q;
          rem_d  = FRAME_R;
        end else begin
          addr_d = addr_q + 24'(BURST_LEN);
          rem_d  = rem_q - BURST_R;
        end
      end
      default: state_d = IDLE;
    endcase
    pop = pix_valid & pix_ready_i & ~flush;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = wr_q + PW'(push);
      rd_d  = rd_q + PW'(pop);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= video_sdram_rdata;
  end

  assign pix_valid_o           = pix_valid;
  assign pix_data_o            = pix_valid ? mem_q[rd_q] : '0;
  assign underflow_o           = unf_q;
  assign busy_o                = busy_q;
  assign video_sdram_cmd_valid = (state_q == REQ);
  assign video_sdram_ack       = (state_q == ACK);
  assign video_sdram_addr_x16  = addr_q;

endmodule

// File: tb/tb_video_burst_fetcher.sv
// Randomized bench for video_burst_fetcher: SDRAM responder, consumer,
// frame-level reference model and a scoreboard monitor.
module tb_video_burst_fetcher;

  localparam int BL = 4;
  localparam int FD = 8;
  localparam int FW = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [23:0] fb_base_i;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic [15:0] pix_data_o;
  logic        underflow_o;
  logic        busy_o;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic        sd_rdy;
  logic        sd_ack;
  logic        resp_valid;
  logic        resp_last;
  logic [15:0] rdata;

  video_burst_fetcher #(
    .BURST_LEN(BL), .FIFO_DEPTH(FD), .FRAME_WORDS(FW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .fb_base_i(fb_base_i),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .pix_data_o(pix_data_o), .underflow_o(underflow_o), .busy_o(busy_o),
    .video_sdram_cmd_valid(cmd_valid), .video_sdram_cmd_ready(cmd_ready),
    .video_sdram_addr_x16(cmd_addr), .video_sdram_rdy(sd_rdy),
    .video_sdram_ack(sd_ack), .video_sdram_resp_valid(resp_valid),
    .video_sdram_resp_last(resp_last), .video_sdram_rdata(rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_cmd  = 0;
  int n_ack  = 0;

  logic [15:0] exp_pix [$];
  logic [23:0] exp_cmd [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] memf(input logic [23:0] a);
    logic [23:0] m;
    m = a * 24'd40503;
    return m[15:0] ^ {8'h00, a[23:16]};
  endfunction

  // Frame-level model: a start replaces everything still expected
  task automatic model_start(input logic [23:0] b);
    exp_pix.delete();
    exp_cmd.delete();
    for (int i = 0; i < FW; i++) exp_pix.push_back(memf(24'(b + 24'(i))));
    for (int j = 0; j < FW / BL; j++) exp_cmd.push_back(24'(b + 24'(j * BL)));
  endtask

  task automatic start_frame(input logic [23:0] b);
    @(posedge clk); #2;
    start_i   = 1'b1;
    fb_base_i = b;
    model_start(b);
    @(posedge clk); #2;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk); #2;
      if (!busy_o && !pix_valid_o && exp_pix.size() == 0) done = 1;
    end
    chk("frame_done", 32'(done), 32'd1);
    chk("cmd_q_empty", 32'(exp_cmd.size()), 32'd0);
  endtask

  // SDRAM responder
  typedef enum int {P_IDLE, P_ACC, P_WAIT, P_WORDS, P_RDY, P_ACK1, P_ACK2} ph_t;
  ph_t phase = P_IDLE;
  int grant_delay = 0;
  int data_delay  = 0;
  bit rnd_delays  = 0;
  int gcnt = 0, dcnt = 0, rcnt = 0, widx = 0;
  int gd = 0, dd = 0, rd = 0;
  logic [23:0] req_addr;

  initial begin
    cmd_ready = 0; resp_valid = 0; resp_last = 0; rdata = '0; sd_rdy = 0;
    forever begin
      @(posedge clk); #1;
      cmd_ready = 0; resp_valid = 0; resp_last = 0; sd_rdy = 0;
      if (rst_i) begin
        phase = P_IDLE;
        gcnt  = 0;
        continue;
      end
      case (phase)
        P_IDLE: if (cmd_valid) begin
          if (gcnt == 0) begin
            gd = rnd_delays ? $urandom_range(0, 3) : grant_delay;
            dd = rnd_delays ? $urandom_range(0, 3) : data_delay;
            rd = rnd_delays ? $urandom_range(0, 2) : 0;
          end
          if (gcnt >= gd) begin
            cmd_ready = 1;
            req_addr  = cmd_addr;
            gcnt      = 0;
            phase     = P_ACC;
          end else gcnt++;
        end
        P_ACC: begin
          chk("cmd_drop_after_accept", 32'(cmd_valid), 32'd0);
          dcnt  = 0;
          phase = P_WAIT;
        end
        P_WAIT: begin
          if (dcnt >= dd) begin
            phase = P_WORDS;
            widx  = 0;
          end else dcnt++;
        end
        P_RDY: begin
          if (rcnt >= rd) begin
            sd_rdy = 1;
            phase  = P_ACK1;
          end else rcnt++;
        end
        P_ACK1: begin
          chk("ack_pulse", 32'(sd_ack), 32'd1);
          phase = P_ACK2;
        end
        P_ACK2: begin
          chk("ack_single", 32'(sd_ack), 32'd0);
          phase = P_IDLE;
        end
        default: ;
      endcase
      if (phase == P_WORDS) begin
        resp_valid = 1;
        rdata      = memf(24'(req_addr + 24'(widx)));
        resp_last  = (widx == BL - 1);
        widx++;
        if (resp_last) begin
          phase = P_RDY;
          rcnt  = 0;
        end
      end
    end
  end

  // Consumer
  int mode   = 0;
  int budget = 0;

  initial begin
    pix_ready_i = 0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        1: pix_ready_i = pix_valid_o;
        2: pix_ready_i = 1;
        3: pix_ready_i = pix_valid_o && ($urandom_range(0, 1) == 1);
        4: begin
          pix_ready_i = pix_valid_o && budget > 0;
          if (pix_ready_i) budget--;
        end
        default: pix_ready_i = 0;
      endcase
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_i) begin
      if (pix_valid_o && pix_ready_i && !start_i) begin
        if (exp_pix.size() == 0) chk("pix_extra", 32'(pix_data_o), 32'hFFFF_FFFF);
        else chk("pix_data", 32'(pix_data_o), 32'(exp_pix.pop_front()));
      end
      if (cmd_valid) begin
        if (exp_cmd.size() == 0) chk("cmd_extra", 32'(cmd_addr), 32'hFFFF_FFFF);
        else chk("cmd_addr", 32'(cmd_addr), 32'(exp_cmd[0]));
        if (cmd_ready) begin
          n_cmd++;
          if (exp_cmd.size() != 0) void'(exp_cmd.pop_front());
        end
      end
      if (sd_ack) n_ack++;
      if (dut.cnt_q > 4'(FD)) begin
        errors++;
        $display("FAIL fifo_overflow: count %0d depth %0d", dut.cnt_q, FD);
      end
    end
  end

  int n0, a0;
  bit hit;
  logic [31:0] r;

  initial begin
    rst_i = 1; start_i = 0; fb_base_i = '0;
    #7;
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_ack", 32'(sd_ack), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid_o), 32'd0);
    chk("rst_pix_data", 32'(pix_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_underflow", 32'(underflow_o), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_i = 0;
    repeat (10) @(posedge clk);
    chk("idle_no_cmd", 32'(n_cmd), 32'd0);

    // Basic frame
    mode = 1;
    n0 = n_cmd; a0 = n_ack;
    start_frame(24'h000100);
    chk("latency_idle", 32'(cmd_valid), 32'd0);
    @(posedge clk); #2;
    chk("latency_req", 32'(cmd_valid), 32'd1);
    wait_done();
    chk("basic_bursts", 32'(n_cmd - n0), 32'd4);
    chk("basic_acks", 32'(n_ack - a0), 32'd4);
    chk("basic_busy", 32'(busy_o), 32'd0);
    chk("basic_underflow", 32'(underflow_o), 32'd0);

    // Backpressure
    mode = 0;
    n0 = n_cmd;
    start_frame(24'h000300);
    repeat (40) @(posedge clk);
    #2;
    chk("bp_two_bursts", 32'(n_cmd - n0), 32'd2);
    chk("bp_valid", 32'(pix_valid_o), 32'd1);
    budget = 4;
    mode = 4;
    repeat (30) @(posedge clk);
    #2;
    chk("bp_third_burst", 32'(n_cmd - n0), 32'd3);
    mode = 1;
    wait_done();

    // Delayed grant
    grant_delay = 10;
    n0 = n_cmd;
    start_frame(24'h000100);
    repeat (5) @(posedge clk);
    #2;
    chk("grant_hold_valid", 32'(cmd_valid), 32'd1);
    chk("grant_not_taken", 32'(n_cmd - n0), 32'd0);
    wait_done();
    grant_delay = 0;

    // Restart mid-burst
    n0 = n_cmd; a0 = n_ack;
    start_frame(24'h000100);
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk); #2;
      if (n_cmd - n0 == 2 && phase == P_WORDS && widx == 3) hit = 1;
    end
    chk("restart_reached", 32'(hit), 32'd1);
    start_i = 1; fb_base_i = 24'h002000;
    model_start(24'h002000);
    @(posedge clk); #2;
    start_i = 0;
    chk("restart_flushed", 32'(pix_valid_o), 32'd0);
    wait_done();
    chk("restart_bursts", 32'(n_cmd - n0), 32'd6);
    chk("restart_acks", 32'(n_ack - a0), 32'd6);

    // Underflow
    mode = 2;
    data_delay = 20;
    start_frame(24'h000700);
    repeat (10) @(posedge clk);
    #2;
    chk("underflow_set", 32'(underflow_o), 32'd1);
    wait_done();
    chk("underflow_sticky", 32'(underflow_o), 32'd1);
    data_delay = 0;
    mode = 1;
    start_frame(24'h000900);
    chk("underflow_cleared", 32'(underflow_o), 32'd0);
    wait_done();

    // Randomized frames, including a base that wraps the address space
    rnd_delays = 1;
    mode = 3;
    for (int f = 0; f < 4; f++) begin
      r = $urandom;
      start_frame(f == 0 ? 24'hFFFFFA : r[23:0]);
      wait_done();
      chk("rnd_underflow", 32'(underflow_o), 32'd0);
    end
    rnd_delays = 0;

    // Asynchronous reset mid-DATA
    mode = 1;
    start_frame(24'h000500);
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk); #2;
      if (phase == P_WORDS) hit = 1;
    end
    chk("reset_reached", 32'(hit), 32'd1);
    #1 rst_i = 1;
    exp_pix.delete();
    exp_cmd.delete();
    #1;
    chk("arst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("arst_ack", 32'(sd_ack), 32'd0);
    chk("arst_pix_valid", 32'(pix_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_i = 0;
    n0 = n_cmd;
    repeat (20) @(posedge clk);
    #2;
    chk("arst_no_req", 32'(n_cmd - n0), 32'd0);
    chk("arst_cmd_low", 32'(cmd_valid), 32'd0);
    start_frame(24'h000600);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_burst_fetcher.md
Name: video_burst_fetcher

Overview:
- Video-side SDRAM client: streams one frame of 16-bit pixels from SDRAM into an internal FIFO and presents them to the pixel pipeline.
- Acts as initiator on the arbiter's video port: one burst read in flight at a time.
- Fixed-length bursts are issued only when the FIFO can absorb a whole burst.
- The fetch is restarted per frame by a start pulse.

Parameters:
- BURST_LEN, 8, words per SDRAM burst; power of 2.
- FIFO_DEPTH, 32, pixel FIFO depth in words; power of 2, >= 2*BURST_LEN.
- FRAME_WORDS, 76800, words fetched per frame; multiple of BURST_LEN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle pulse: latch fb_base_i, flush FIFO, restart frame fetch.
- fb_base_i  in  24  frame base address in 16-bit words.
- pix_valid_o  out  1  FIFO head valid.
- pix_ready_i  in  1  consumer pops on pix_valid_o && pix_ready_i.
- pix_data_o  out  16  FIFO head word.
- underflow_o  out  1  sticky; cleared by start_i.
- busy_o  out  1  high from start until last burst acked.
- video_sdram_cmd_valid  out  1  burst request.
- video_sdram_cmd_ready  in  1  arbiter ready (combinational in arbiter).
- video_sdram_addr_x16  out  24  burst start address.
- video_sdram_rdy  in  1  controller done with transaction.
- video_sdram_ack  out  1  one-cycle release pulse to arbiter.
- video_sdram_resp_valid  in  1  read word valid.
- video_sdram_resp_last  in  1  last word of burst.
- video_sdram_rdata  in  16  read data.

Behaviour:
- Reset (async): all outputs 0; FSM IDLE; FIFO empty; counters 0; busy_o = 0; underflow_o = 0.
- Registers:
  - addr (24 b).
  - remaining (17 b; width = clog2(FRAME_WORDS+1)).
  - FIFO count (clog2(FIFO_DEPTH)+1 b).
  - restart_pending.
  - got_last.
- Address is held stable from REQ through ACK; the arbiter muxes it combinationally for the whole transaction.
- video_sdram_cmd_valid and video_sdram_ack are driven from FSM state (registered decode).
- FSM:
  - IDLE:
    - If start_i: addr <= fb_base_i; remaining <= FRAME_WORDS; flush FIFO; underflow_o <= 0; busy_o <= 1.
    - Else if remaining != 0 && count <= FIFO_DEPTH-BURST_LEN: -> REQ.
    - If remaining == 0 in IDLE, busy_o <= 0.
  - REQ: cmd_valid = 1. When cmd_ready sampled high -> DATA, got_last <= 0. cmd_valid drops the cycle after acceptance.
  - DATA:
    - Each resp_valid pushes rdata into the FIFO, unless discarding.
    - resp_valid && resp_last sets got_last.
    - When got_last (or resp_last this cycle) and video_sdram_rdy -> ACK.
  - ACK:
    - video_sdram_ack = 1 for exactly this cycle; -> IDLE.
    - addr += BURST_LEN (24-bit wrap, modulo 2^24); remaining -= BURST_LEN.
    - If restart_pending: perform the start actions instead; clear restart_pending.
- Room check reserves a whole burst, so a FIFO push never finds the FIFO full.
  - Bench asserts: push while full = error.
  - Words beyond BURST_LEN before resp_last = error.
- FIFO: push and pop in the same cycle leave count unchanged. pix_data_o valid whenever pix_valid_o; zero-latency first-word-fall-through read from the storage array.
- Start mid-transaction (REQ accepted, DATA, ACK):
  - The SDRAM transaction is never aborted.
  - Set restart_pending; remaining words of the current burst are discarded (not pushed).
  - FIFO is flushed immediately; new frame begins at ACK.
- Start in REQ before acceptance: cmd_valid is already asserted, so treat as mid-transaction; cmd_valid must not drop without acceptance.
- Start in IDLE takes effect that cycle and suppresses the REQ transition.
- Start coincident with a pop: flush wins.
- underflow_o: set when busy_o && pix_ready_i && !pix_valid_o && (remaining != 0 || fetch in progress). Stays set until start_i.
- End of frame: remaining reaches 0 after the final ACK. FSM idles; FIFO drains normally; busy_o falls.
- Latency: start_i (IDLE, empty FIFO) to cmd_valid = 2 cycles (IDLE eval, REQ).

Test Plan (bench params BURST_LEN=4, FIFO_DEPTH=8, FRAME_WORDS=16):
1. Basic frame: start_i with fb_base_i=0x000100, pix_ready_i=1.
   - Responder grants immediately; each burst returns 4 words, resp_last on 4th, rdy 1 cycle later.
   - Requires 4 bursts at addrs 0x100/0x104/0x108/0x10C, each acked exactly one cycle.
   - 16 words out in order; busy_o falls; underflow_o=0.
2. Backpressure: pix_ready_i=0.
   - Exactly 2 bursts are issued (count 8); no third cmd_valid.
   - Pop 4 words -> third burst issues; no FIFO overflow.
3. Delayed grant: hold cmd_ready=0 for 10 cycles.
   - cmd_valid and addr 0x100 stay stable all 10 cycles.
   - Accepted on first ready cycle; cmd_valid low next cycle.
4. Restart mid-burst: start_i with fb_base_i=0x2000 after 2 of 4 words of burst 2.
   - Remaining 2 words are dropped; ack still pulses.
   - FIFO is empty after flush; next cmd_valid addr=0x2000; remaining restarts at 16.
5. Underflow: responder waits 20 cycles before data, pix_ready_i=1.
   - underflow_o=1 and stays 1 after data arrives.
   - Next start_i clears it.
6. Async reset: assert rst_i mid-DATA, asynchronous to clock edge.
   - cmd_valid, ack, pix_valid_o, busy_o go to 0 immediately.
   - After release, no request is issued until start_i.
